// File: rtl/ps2_key_frontend.sv
// PS/2 keyboard front end: synchronises the bus, receives and validates 11-bit
// frames, and decodes Set-2 make/break/E0 sequences into a held-key state.
module ps2_key_frontend #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       light,
    output logic [7:0] num,
    output logic       frame_err
);

    localparam int WD_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    logic [2:0]      r_clk_s, r_dat_s;
    logic [3:0]      r_bitcnt;
    logic [10:0]     r_frame;
    logic            r_done;
    logic [WD_W-1:0] r_idle;
    logic            r_byte_vld;
    logic [7:0]      r_byte;
    state_t          r_state;

    logic   w_fall, w_bit, w_ok, w_ignore;
    logic   w_do_make, w_do_brk, w_ext;
    state_t w_nxt;

    // Index 0 is the first synchroniser stage; falling edge seen between stages 2 and 3.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clk_s <= 3'b111;
            r_dat_s <= 3'b111;
        end else begin
            r_clk_s <= {r_clk_s[1:0], ps2_clk};
            r_dat_s <= {r_dat_s[1:0], ps2_data};
        end
    end

    assign w_fall = ~r_clk_s[1] & r_clk_s[2];
    assign w_bit  = r_dat_s[2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bitcnt <= 4'd0;
            r_frame  <= 11'd0;
            r_done   <= 1'b0;
            r_idle   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_fall) begin
                r_idle  <= '0;
                r_frame <= {w_bit, r_frame[10:1]};
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= 4'd0;
                    r_done   <= 1'b1;
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_idle != WD_MAX) begin
                r_idle <= r_idle + 1'b1;
            end else if (r_bitcnt != 4'd0) begin
                r_bitcnt <= 4'd0;
            end
        end
    end

    // Frame is LSB-first: [0]=start, [8:1]=data, [9]=odd parity, [10]=stop.
    assign w_ok = ~r_frame[0] & r_frame[10] & (^r_frame[9:1]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_byte_vld <= 1'b0;
            r_byte     <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            r_byte_vld <= r_done & w_ok;
            frame_err  <= r_done & ~w_ok;
            if (r_done) r_byte <= r_frame[8:1];
        end
    end

    assign w_ignore = (r_byte == 8'hAA) || (r_byte == 8'hFA) || (r_byte == 8'hEE) ||
                      (r_byte == 8'hFE) || (r_byte == 8'h00);

    always_comb begin
        w_nxt     = r_state;
        w_do_make = 1'b0;
        w_do_brk  = 1'b0;
        w_ext     = 1'b0;
        if (r_byte_vld) begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_byte == 8'hE0)      w_nxt = S_EXT;
                    else if (r_byte == 8'hF0) w_nxt = S_BRK;
                    else if (!w_ignore)       w_do_make = 1'b1;
                end
                S_EXT: begin
                    w_ext = 1'b1;
                    if (r_byte == 8'hF0)      w_nxt = S_EXT_BRK;
                    else if (r_byte == 8'hE0) w_nxt = S_EXT;
                    else if (!w_ignore) begin
                        w_do_make = 1'b1;
                        w_nxt     = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_do_brk = 1'b1;
                    w_nxt    = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_do_brk = 1'b1;
                    w_ext    = 1'b1;
                    w_nxt    = S_IDLE;
                end
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    // A make of the key already held is typematic repeat and is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            scancode <= 8'h00;
            extended <= 1'b0;
            light    <= 1'b0;
            num      <= 8'h00;
        end else begin
            r_state <= w_nxt;
            if (w_do_make && !(light && r_byte == scancode && w_ext == extended)) begin
                scancode <= r_byte;
                extended <= w_ext;
                light    <= 1'b1;
                num      <= num + 8'd1;
            end else if (w_do_brk && r_byte == scancode && w_ext == extended) begin
                light <= 1'b0;
            end
        end
    end

endmodule
